sdram_arbiter: RTL and testbench

Two-port request arbiter with built-in auto-refresh scheduling, placed between user logic and the `sdram` controller on the Tang Primer 20K design. It runs on the 54 MHz main clock. Two clients use a simple req/ack handshake. The arbiter alternates grants between them round-robin, and issues a `refresh` every 7.8 µs with priority over both clients. Each access becomes a single-cycle `rd`/`wr`/`refresh` pulse to the controller, and the arbiter tracks the controller's `busy` to detect completion.

---
 rtl/sdram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port round-robin SDRAM request arbiter with auto-refresh
// Refresh has priority over clients; each access is one rd/wr/refresh pulse, completion seen via mem_busy.
module sdram_arbiter #(
  parameter int FREQ           = 54_000_000,
  parameter int REFRESH_CYCLES = FREQ/1000/1000*7813/1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [24:0] p0_addr,
  input  logic [15:0] p0_din,
  output logic        p0_ack,
  output logic [15:0] p0_dout,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [24:0] p1_addr,
  input  logic [15:0] p1_din,
  output logic        p1_ack,
  output logic [15:0] p1_dout,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_refresh,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_busy,
  output logic [23:0] refresh_count
);

  localparam logic [11:0] RC     = 12'(REFRESH_CYCLES);
  localparam logic [11:0] RT_MAX = 12'(2*REFRESH_CYCLES-2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        is_ref_q, is_ref_d;
  logic        we_q, we_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        mem_ref_q, mem_ref_d;
  logic [24:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_din_q, mem_din_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [15:0] dout0_q, dout0_d;
  logic [15:0] dout1_q, dout1_d;
  logic [11:0] refresh_time_q, refresh_time_d;
  logic        pend_q, pend_d;
  logic [23:0] rcount_q, rcount_d;
  logic        pick1;
  logic        sel_we;

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    last_d         = last_q;
    is_ref_d       = is_ref_q;
    we_d           = we_q;
    mem_rd_d       = 1'b0;
    mem_wr_d       = 1'b0;
    mem_ref_d      = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_din_d      = mem_din_q;
    ack0_d         = 1'b0;
    ack1_d         = 1'b0;
    dout0_d        = dout0_q;
    dout1_d        = dout1_q;
    rcount_d       = rcount_q;
    // On a tie, port 1 wins only when port 0 was granted last.
    pick1          = p1_req && (!p0_req || !last_q);
    sel_we         = pick1 ? p1_we : p0_we;
    refresh_time_d = (refresh_time_q == RT_MAX) ? refresh_time_q : refresh_time_q + 12'd1;
    pend_d         = pend_q || (refresh_time_q == RC);

    case (state_q)
      IDLE: begin
        if (!mem_busy) begin
          if (pend_q) begin
            mem_ref_d      = 1'b1;
            is_ref_d       = 1'b1;
            refresh_time_d = refresh_time_q - RC;
            pend_d         = 1'b0;
            rcount_d       = rcount_q + 24'd1;
            state_d        = ISSUE;
          end else if (p0_req || p1_req) begin
            gnt_d      = pick1;
            last_d     = pick1;
            is_ref_d   = 1'b0;
            we_d       = sel_we;
            mem_addr_d = pick1 ? p1_addr : p0_addr;
            mem_din_d  = pick1 ? p1_din : p0_din;
            mem_wr_d   = sel_we;
            mem_rd_d   = !sel_we;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!mem_busy) begin
          if (is_ref_q) begin
            state_d = IDLE;
          end else begin
            if (!we_q && !gnt_q) dout0_d = mem_dout;
            if (!we_q && gnt_q)  dout1_d = mem_dout;
            ack0_d  = !gnt_q;
            ack1_d  = gnt_q;
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      gnt_q          <= 1'b0;
      last_q         <= 1'b1;
      is_ref_q       <= 1'b0;
      we_q           <= 1'b0;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      mem_ref_q      <= 1'b0;
      mem_addr_q     <= '0;
      mem_din_q      <= '0;
      ack0_q         <= 1'b0;
      ack1_q         <= 1'b0;
      dout0_q        <= '0;
      dout1_q        <= '0;
      refresh_time_q <= '0;
      pend_q         <= 1'b0;
      rcount_q       <= '0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      last_q         <= last_d;
      is_ref_q       <= is_ref_d;
      we_q           <= we_d;
      mem_rd_q       <= mem_rd_d;
      mem_wr_q       <= mem_wr_d;
      mem_ref_q      <= mem_ref_d;
      mem_addr_q     <= mem_addr_d;
      mem_din_q      <= mem_din_d;
      ack0_q         <= ack0_d;
      ack1_q         <= ack1_d;
      dout0_q        <= dout0_d;
      dout1_q        <= dout1_d;
      refresh_time_q <= refresh_time_d;
      pend_q         <= pend_d;
      rcount_q       <= rcount_d;
    end
  end

  assign mem_rd        = mem_rd_q;
  assign mem_wr        = mem_wr_q;
  assign mem_refresh   = mem_ref_q;
  assign mem_addr      = mem_addr_q;
  assign mem_din       = mem_din_q;
  assign p0_ack        = ack0_q;
  assign p1_ack        = ack1_q;
  assign p0_dout       = dout0_q;
  assign p1_dout       = dout1_q;
  assign refresh_count = rcount_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - scoreboard bench for sdram_arbiter
// Controller model: busy for a programmable number of cycles per command, word memory for reads.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [24:0] p0_addr = '0, p1_addr = '0;
  logic [15:0] p0_din = '0, p1_din = '0;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_dout, p1_dout;
  logic        mem_rd, mem_wr, mem_refresh;
  logic [24:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = '0;
  logic        mem_busy;
  logic [23:0] refresh_count;

  sdram_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din),
    .p0_ack(p0_ack), .p0_dout(p0_dout),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din),
    .p1_ack(p1_ack), .p1_dout(p1_dout),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_refresh(mem_refresh),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_busy(mem_busy), .refresh_count(refresh_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [24:0] addr;
    logic [15:0] din;
  } cmd_t;

  cmd_t        exp_q[$];
  logic [15:0] dq0[$];
  logic [15:0] dq1[$];
  int          ref_cyc[$];
  int          total = 0, bad = 0;
  int          ref_seen = 0, cmd_cyc = 0, rst_cyc = 0, rt_max = 0;
  int          busy_len = 3, busy_cnt = 0;
  logic        busy_hold = 1'b0, busy_m = 1'b0;
  logic [15:0] mem [int];
  cmd_t        mon_e;

  assign mem_busy = busy_hold | busy_m;

  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
      busy_m   = 1'b0;
    end else begin
      if (busy_cnt > 0) busy_cnt--;
      if (mem_rd || mem_wr || mem_refresh) busy_cnt = busy_len;
      busy_m = (busy_cnt > 0);
      if (mem_wr) mem[int'(mem_addr)] = mem_din;
      if (mem_rd) mem_dout = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 16'hDEAD;
    end
  end

  // Scoreboard monitor: every client command must match the next expected one in order.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd || mem_wr) begin
        cmd_cyc = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got rd=%0b wr=%0b addr=%h, required no command", mem_rd, mem_wr, mem_addr);
        end else begin
          mon_e = exp_q.pop_front();
          if (mem_wr !== mon_e.we || mem_rd !== !mon_e.we || mem_addr !== mon_e.addr ||
              (mon_e.we && mem_din !== mon_e.din)) begin
            bad++;
            $display("FAIL sb_cmd: got wr=%0b addr=%h din=%h, required wr=%0b addr=%h din=%h",
                     mem_wr, mem_addr, mem_din, mon_e.we, mon_e.addr, mon_e.din);
          end
        end
      end
      if (mem_refresh) begin
        ref_seen++;
        ref_cyc.push_back(cyc);
      end
      if (int'(dut.refresh_time_q) > rt_max) rt_max = int'(dut.refresh_time_q);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    dq0.delete();
    dq1.delete();
    ref_cyc.delete();
    ref_seen = 0;
    rt_max   = 0;
    reset    = 1'b0;
    rst_cyc  = cyc;
  endtask

  task automatic start_req(input int port, input logic we, input logic [24:0] addr,
                           input logic [15:0] din, input logic [15:0] exp_dout);
    cmd_t c;
    c.we = we; c.addr = addr; c.din = din;
    exp_q.push_back(c);
    if (port == 0) begin
      if (!we) dq0.push_back(exp_dout);
      p0_we = we; p0_addr = addr; p0_din = din; p0_req = 1'b1;
    end else begin
      if (!we) dq1.push_back(exp_dout);
      p1_we = we; p1_addr = addr; p1_din = din; p1_req = 1'b1;
    end
  endtask

  task automatic serve(input int n, input bit hold, output int ack_cyc);
    int acks = 0;
    int t = 0;
    logic [15:0] e;
    ack_cyc = 0;
    while (acks < n && t < 3000) begin
      @(negedge clk);
      t++;
      if (p0_ack) begin
        acks++;
        ack_cyc = cyc;
        if (!p0_we && dq0.size() > 0) begin
          total++;
          e = dq0.pop_front();
          if (p0_dout !== e) begin bad++; $display("FAIL p0_dout: got %h, required %h", p0_dout, e); end
        end
        if (!hold) p0_req = 1'b0;
      end
      if (p1_ack) begin
        acks++;
        ack_cyc = cyc;
        if (!p1_we && dq1.size() > 0) begin
          total++;
          e = dq1.pop_front();
          if (p1_dout !== e) begin bad++; $display("FAIL p1_dout: got %h, required %h", p1_dout, e); end
        end
        if (!hold) p1_req = 1'b0;
      end
      if (acks >= n) begin p0_req = 1'b0; p1_req = 1'b0; end
    end
    if (acks < n) begin
      total++; bad++;
      $display("FAIL ack_timeout: got %0d acks, required %0d", acks, n);
      p0_req = 1'b0; p1_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({mem_rd, mem_wr, mem_refresh, p0_ack, p1_ack} !== 5'b0) begin
      bad++; $display("FAIL reset_pulses: got %b, required 00000", {mem_rd, mem_wr, mem_refresh, p0_ack, p1_ack});
    end
    total++;
    if (mem_addr !== 25'h0 || mem_din !== 16'h0) begin
      bad++; $display("FAIL reset_mem_bus: got addr=%h din=%h, required 0", mem_addr, mem_din);
    end
    total++;
    if (p0_dout !== 16'h0 || p1_dout !== 16'h0) begin
      bad++; $display("FAIL reset_dout: got %h %h, required 0", p0_dout, p1_dout);
    end
    total++;
    if (refresh_count !== 24'h0) begin
      bad++; $display("FAIL reset_refresh_count: got %0d, required 0", refresh_count);
    end
  endtask

  task automatic test_write_read();
    int rc, ac;
    busy_len = 3;
    @(negedge clk);
    start_req(0, 1'b1, 25'h0000001, 16'h1234, 16'h0);
    rc = cyc;
    serve(1, 1'b0, ac);
    total++;
    if (cmd_cyc - rc != 1) begin bad++; $display("FAIL wr_cmd_latency: got %0d, required 1", cmd_cyc - rc); end
    total++;
    if (ac - cmd_cyc != 4) begin bad++; $display("FAIL wr_ack_latency: got %0d, required 4", ac - cmd_cyc); end
    @(negedge clk);
    start_req(0, 1'b0, 25'h0000001, 16'h0, 16'h1234);
    serve(1, 1'b0, ac);
    total++;
    if (p0_dout !== 16'h1234) begin bad++; $display("FAIL rd_dout_held: got %h, required 1234", p0_dout); end
  endtask

  task automatic test_tie();
    int ac;
    do_reset();
    @(negedge clk);
    start_req(0, 1'b1, 25'h0000100, 16'hAAAA, 16'h0);
    start_req(1, 1'b1, 25'h0000200, 16'hBBBB, 16'h0);
    serve(2, 1'b0, ac);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      start_req(0, 1'b0, 25'h0000200, 16'h0, 16'hBBBB);
      start_req(1, 1'b0, 25'h0000100, 16'h0, 16'hAAAA);
    end
    serve(4, 1'b1, ac);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL tie_leftover: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_busy_after_reset();
    int pulses = 0;
    int rc, ac, t;
    busy_hold = 1'b1;
    do_reset();
    start_req(1, 1'b1, 25'h1FFFFFF, 16'hFFFF, 16'h0);
    repeat (200) begin
      @(negedge clk);
      if (mem_rd || mem_wr || mem_refresh) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL busy_hold_pulses: got %0d, required 0", pulses); end
    busy_hold = 1'b0;
    rc = cyc;
    t = 0;
    while (!mem_wr && t < 20) begin @(negedge clk); t++; end
    total++;
    if (!mem_wr || cyc - rc != 1) begin
      bad++; $display("FAIL busy_release_latency: got %0d, required 1", cyc - rc);
    end
    serve(1, 1'b0, ac);
  endtask

  task automatic test_long_access(input int len, input int exp_gap_lo, input int exp_gap_hi,
                                  input bit rel_to_reset, input int exp_rt_max);
    int ac, t, gap;
    do_reset();
    busy_len = len;
    @(negedge clk);
    start_req(0, 1'b1, 25'h00ABCDE, 16'h5A5A, 16'h0);
    serve(1, 1'b0, ac);
    busy_len = 3;
    t = 0;
    while (ref_cyc.size() < 2 && t < 1500) begin @(negedge clk); t++; end
    total++;
    if (ref_cyc.size() < 2) begin
      bad++; $display("FAIL long_refresh_timeout: got %0d refreshes, required 2", ref_cyc.size());
    end else begin
      total++;
      if (ref_cyc[0] - ac != 2) begin
        bad++; $display("FAIL long_refresh_after_ack: got %0d, required 2", ref_cyc[0] - ac);
      end
      gap = rel_to_reset ? ref_cyc[1] - rst_cyc : ref_cyc[1] - ref_cyc[0];
      if (gap < exp_gap_lo || gap > exp_gap_hi) begin
        bad++; $display("FAIL long_next_refresh: got %0d, required %0d..%0d", gap, exp_gap_lo, exp_gap_hi);
      end
    end
    total++;
    if (rt_max > exp_rt_max) begin
      bad++; $display("FAIL refresh_time_max: got %0d, required <= %0d", rt_max, exp_rt_max);
    end
  endtask

  task automatic test_saturation();
    total++;
    if (rt_max != 840) begin bad++; $display("FAIL refresh_time_saturate: got %0d, required 840", rt_max); end
  endtask

  task automatic test_refresh_cadence();
    int d;
    do_reset();
    busy_len = 3;
    repeat (4230) @(negedge clk);
    total++;
    if (ref_seen != 10) begin bad++; $display("FAIL cadence_count: got %0d, required 10", ref_seen); end
    total++;
    if (refresh_count !== 24'(ref_seen)) begin
      bad++; $display("FAIL refresh_count: got %0d, required %0d", refresh_count, ref_seen);
    end
    for (int i = 1; i < ref_cyc.size(); i++) begin
      d = ref_cyc[i] - ref_cyc[i-1];
      total++;
      if (d < 421 || d > 422) begin bad++; $display("FAIL cadence_interval%0d: got %0d, required 421..422", i, d); end
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    int acks = 0;
    busy_len = 50;
    @(negedge clk);
    start_req(1, 1'b0, 25'h0000100, 16'h0, 16'hAAAA);
    while (!mem_rd && t < 1000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    reset  = 1'b1;
    p1_req = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_rd, mem_wr, mem_refresh, p0_ack, p1_ack} !== 5'b0 || mem_addr !== 25'h0 ||
        mem_din !== 16'h0 || p0_dout !== 16'h0 || p1_dout !== 16'h0) begin
      bad++; $display("FAIL mid_reset_outputs: got addr=%h din=%h d0=%h d1=%h, required 0",
                      mem_addr, mem_din, p0_dout, p1_dout);
    end
    total++;
    if (refresh_count !== 24'h0) begin
      bad++; $display("FAIL mid_reset_count: got %0d, required 0", refresh_count);
    end
    reset = 1'b0;
    dq1.delete();
    exp_q.delete();
    repeat (60) begin
      @(negedge clk);
      if (p1_ack) acks++;
    end
    total++;
    if (acks != 0) begin bad++; $display("FAIL mid_reset_ack: got %0d, required 0", acks); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_busy_after_reset();
    test_long_access(600, 843, 847, 1'b1, 840);
    test_long_access(1000, 3, 5, 1'b0, 840);
    test_saturation();
    test_refresh_cadence();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
